// File: rtl/fp_stream_cvt.sv
// Streaming two's-complement to small floating-point converter.
// Normalises by serial left shifts, then rounds with a selectable mode.
module fp_stream_cvt #(
    parameter int unsigned EW = 3,
    parameter int unsigned FW = 5,
    parameter int unsigned DW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_d,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [FW-1:0] out_f,
    output logic          out_sat
);

    localparam int unsigned MW = DW - 1;
    localparam logic [EW-1:0] E_MAX = '1;

    generate
        if (DW != FW + (1 << EW)) begin : g_bad_width
            $error("fp_stream_cvt: DW must equal FW + 2**EW");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t state, state_n;

    logic [MW-1:0] m_q;
    logic [EW-1:0] e_q;
    logic          sign_q;
    logic [1:0]    mode_q;
    logic          sat_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = NORM;
            NORM:    if (e_q == '0 || m_q[MW-1]) state_n = ROUND;
            ROUND:   state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (state == IDLE) in_ready  = 1'b1;
        if (state == DONE) out_valid = 1'b1;
    end

    // Magnitude of the incoming operand; the most-negative value clamps
    logic [DW-1:0] neg_d;
    logic [MW-1:0] mag;
    logic          is_min;
    always_comb begin
        neg_d  = DW'(0) - in_d;
        is_min = (in_d == {1'b1, {MW{1'b0}}});
        mag    = in_d[DW-1] ? neg_d[MW-1:0] : in_d[MW-1:0];
        if (is_min) mag = '1;
    end

    // Rounding of the normalised significand
    logic [FW-1:0] f_raw;
    logic          r_bit;
    logic          t_bit;
    logic          inc;
    logic [FW:0]   f_sum;
    logic [FW-1:0] f_res;
    logic [EW-1:0] e_res;
    logic          sat_res;
    always_comb begin
        f_raw   = m_q[MW-1 -: FW];
        r_bit   = (e_q != '0) && m_q[MW-1-FW];
        t_bit   = (e_q != '0) && (|m_q[MW-2-FW:0]);
        inc     = ((mode_q == 2'd1) && r_bit) ||
                  ((mode_q == 2'd2) && r_bit && (t_bit || f_raw[0]));
        f_sum   = (FW+1)'(f_raw) + (FW+1)'(inc);
        f_res   = f_sum[FW-1:0];
        e_res   = e_q;
        sat_res = sat_q;
        if (f_sum[FW]) begin
            if (e_q != E_MAX) begin
                f_res = {1'b1, {(FW-1){1'b0}}};
                e_res = e_q + EW'(1);
            end else begin
                f_res   = '1;
                e_res   = E_MAX;
                sat_res = 1'b1;
            end
        end
    end

    // Operand capture, serial normalisation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q     <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
            mode_q  <= 2'd0;
            sat_q   <= 1'b0;
            out_s   <= 1'b0;
            out_e   <= '0;
            out_f   <= '0;
            out_sat <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_q    <= mag;
                        e_q    <= E_MAX;
                        sign_q <= in_d[DW-1];
                        mode_q <= in_mode;
                        sat_q  <= is_min;
                    end
                end
                NORM: begin
                    if (e_q != '0 && !m_q[MW-1]) begin
                        m_q <= {m_q[MW-2:0], 1'b0};
                        e_q <= e_q - EW'(1);
                    end
                end
                ROUND: begin
                    out_s   <= sign_q;
                    out_e   <= e_res;
                    out_f   <= f_res;
                    out_sat <= sat_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_stream_cvt.sv
// Directed self-checking bench for fp_stream_cvt at default parameters.
module tb_fp_stream_cvt;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_d;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic        out_s;
    logic [2:0]  out_e;
    logic [4:0]  out_f;
    logic        out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    fp_stream_cvt #(.EW(3), .FW(5), .DW(13)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] d;
        logic [1:0]  mode;
        logic        s;
        logic [2:0]  e;
        logic [4:0]  f;
        logic        sat;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        check($sformatf("v%0d_ready", idx), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_d     = v.d;
        in_mode  = v.mode;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_d     = ~v.d;
        in_mode  = ~v.mode;
        check($sformatf("v%0d_busy", idx), 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_s", idx), 32'(out_s), 32'(v.s));
        check($sformatf("v%0d_e", idx), 32'(out_e), 32'(v.e));
        check($sformatf("v%0d_f", idx), 32'(out_f), 32'(v.f));
        check($sformatf("v%0d_sat", idx), 32'(out_sat), 32'(v.sat));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d_release", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        logic seen;
        logic ok;

        //         d        mode  s     e     f      sat  lat
        vecs[0]  = '{13'd422,  2'd1, 1'b0, 3'd4, 5'd26, 1'b0, 5};
        vecs[1]  = '{13'd106,  2'd0, 1'b0, 3'd2, 5'd26, 1'b0, 7};
        vecs[2]  = '{13'd106,  2'd1, 1'b0, 3'd2, 5'd27, 1'b0, 7};
        vecs[3]  = '{13'd106,  2'd2, 1'b0, 3'd2, 5'd26, 1'b0, 7};
        vecs[4]  = '{13'd106,  2'd3, 1'b0, 3'd2, 5'd26, 1'b0, 7};
        vecs[5]  = '{13'd126,  2'd1, 1'b0, 3'd3, 5'd16, 1'b0, 7};
        vecs[6]  = '{13'd126,  2'd0, 1'b0, 3'd2, 5'd31, 1'b0, 7};
        vecs[7]  = '{13'd126,  2'd2, 1'b0, 3'd3, 5'd16, 1'b0, 7};
        vecs[8]  = '{13'd4095, 2'd1, 1'b0, 3'd7, 5'd31, 1'b1, 2};
        vecs[9]  = '{13'd4095, 2'd0, 1'b0, 3'd7, 5'd31, 1'b0, 2};
        vecs[10] = '{13'h1000, 2'd0, 1'b1, 3'd7, 5'd31, 1'b1, 2};
        vecs[11] = '{13'd4097, 2'd2, 1'b1, 3'd7, 5'd31, 1'b1, 2};
        vecs[12] = '{13'd0,    2'd0, 1'b0, 3'd0, 5'd0,  1'b0, 9};
        vecs[13] = '{13'h1FFF, 2'd2, 1'b1, 3'd0, 5'd1,  1'b0, 9};
        vecs[14] = '{13'd55,   2'd2, 1'b0, 3'd1, 5'd28, 1'b0, 8};
        vecs[15] = '{13'd107,  2'd2, 1'b0, 3'd2, 5'd27, 1'b0, 7};
        vecs[16] = '{13'd7770, 2'd1, 1'b1, 3'd4, 5'd26, 1'b0, 5};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_d      = '0;
        in_mode   = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outs", 32'({out_s, out_e, out_f, out_sat}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i], i);

        // Back-pressure: result must hold while out_ready stays low
        @(negedge clk);
        in_valid = 1'b1;
        in_d     = 13'd422;
        in_mode  = 2'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("stall_lat", 32'(k), 32'd5);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            ok = out_valid && !in_ready && ({out_s, out_e, out_f, out_sat} == {1'b0, 3'd4, 5'd26, 1'b0});
            check($sformatf("stall_hold%0d", c), 32'(ok), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of normalisation discards the operand
        @(negedge clk);
        in_valid = 1'b1;
        in_d     = 13'd1;
        in_mode  = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outs", 32'({out_s, out_e, out_f, out_sat}), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);

        // Reset wins over a simultaneous accept
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_d     = 13'd422;
        @(posedge clk);
        #1;
        check("rstacc_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstacc_idle", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
